alu_mult_seq: RTL and testbench
===============================

Name: alu_mult_seq

Overview:
- Iterative unsigned 32x32 shift-add multiplier that acts as the initiator side of alu_file_if: it drives porta, portb and aluop, and reads outport.
- All accumulation additions run through the shared ALU. Shifting, control and overflow tracking are local.
- Sits beside the execute stage as a multi-cycle MUL unit with valid/ready request and response channels.
- Returns the low 32 bits of the product plus an unsigned-overflow flag and a zero flag.

Parameters:
- WIDTH, 32, operand/result width; must equal the bit width of word_t.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept; high only in IDLE.
- opa  input  32  multiplicand (word_t).
- opb  input  32  multiplier (word_t).
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- result  output  32  low word of opa*opb.
- ovf  output  1  true product exceeds 32 bits.
- zero  output  1  result == 0.
- alu_porta  output  32  to alu_file_if.porta; driven from acc register.
- alu_portb  output  32  to alu_file_if.portb; driven from mcand register.
- alu_aluop  output  aluop_t  to alu_file_if.aluop; constant ALU_ADD.
- alu_outport  input  32  from alu_file_if.outport. neg_f, over_f and zero_f are not consumed.

Behaviour:
- Reset (synchronous, active-high) has priority over all other events. On the reset edge:
  - state <= IDLE.
  - acc, mcand, mplier, cnt, result, ovf, zero <= 0.
  - resp_valid <= 0; req_ready = 1 after reset.
- Reset asserted mid-transaction discards the transaction; no response is produced.
- FSM states: IDLE, MUL, DONE. req_ready = (state == IDLE), combinational from the state register.
- IDLE:
  - On req_valid && req_ready: acc <= 0, mcand <= opa, mplier <= opb, cnt <= 0, ovf <= 0, state <= MUL.
  - Input values are sampled only on that edge.
- MUL, when mplier == 0: result <= acc, zero <= (acc == 0), resp_valid <= 1, state <= DONE.
- MUL, otherwise, all updates on the same edge:
  - If mplier[0] == 1: acc <= alu_outport. If alu_outport < acc (unsigned carry out), ovf <= 1.
  - If mcand[31] == 1 and (mplier >> 1) != 0: ovf <= 1 (a lost bit would be added later).
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
- Latency from the accept edge to resp_valid high:
  - msb_index(opb) + 2 edges; opb == 0 gives 1 edge.
  - Maximum 33 edges, when opb[31] == 1. cnt never exceeds 32.
- DONE:
  - resp_valid held high; result, ovf and zero held stable until resp_valid && resp_ready.
  - On that handshake: resp_valid <= 0, state <= IDLE.
  - No request is accepted in DONE, so there is a minimum one-cycle bubble between transactions.
- ALU port drive is continuous: porta = acc, portb = mcand, aluop = ALU_ADD in every state. outport is captured only in MUL when mplier[0] == 1.
- ALU is assumed purely combinational, with a single-cycle path from acc/mcand to the acc capture.

Decomposition:
- word_t and aluop_t (ALU_ADD) come from cpu_types_pkg.
- Add to cpu_types_pkg:
  - typedef enum logic [1:0] {MS_IDLE, MS_MUL, MS_DONE} mult_state_t.
  - localparam MULT_CNT_W = 6.
- No sub-module inside the block. The testbench instantiates the existing alu_file, bound through alu_file_if: af modport on the ALU, tb modport signals mapped to this block's alu_* ports.

Test Plan:
- Reset for 2 cycles -> req_ready=1, resp_valid=0, result=0, ovf=0, zero=0; alu_aluop=ALU_ADD.
- opa=7, opb=6, resp_ready=1 -> result=42, ovf=0, zero=0; resp_valid rises 4 edges after accept.
- opa=0xDEADBEEF, opb=0 -> result=0, zero=1, ovf=0; resp_valid 1 edge after accept.
- opa=0xFFFFFFFF, opb=0xFFFFFFFF -> result=0x00000001, ovf=1; latency 33 edges.
- opa=0x00010000, opb=0x00010000 -> result=0, zero=1, ovf=1 (shift-loss path).
- Backpressure and reset:
  - opa=3, opb=5 with resp_ready=0 for 10 cycles -> result=15 held, resp_valid=1, req_ready=0 throughout; then resp_ready=1 -> IDLE next edge.
  - Separately, RST high during MUL -> next edge IDLE, resp_valid=0, no response.

Source files
------------

// File: rtl/cpu_types_pkg.sv
`default_nettype none
//==============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU datapath types: machine word, ALU opcodes and the
//               sequential multiplier state encoding.
// Revision    : 1.0 - initial release
//==============================================================================
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU
    } aluop_t;

    // Sequential multiplier control states
    typedef enum logic [1:0] {
        MS_IDLE,
        MS_MUL,
        MS_DONE
    } mult_state_t;

    localparam int MULT_CNT_W = 6;

endpackage
`default_nettype wire

// File: rtl/alu_file_if.sv
`default_nettype none
//==============================================================================
// Module      : alu_file_if
// Description : Bundle between an ALU and the unit that initiates operations.
//               af = ALU side, tb = initiator side.
// Revision    : 1.0 - initial release
//==============================================================================
interface alu_file_if;
    import cpu_types_pkg::*;

    word_t  porta;
    word_t  portb;
    aluop_t aluop;
    word_t  outport;
    logic   neg_f;
    logic   over_f;
    logic   zero_f;

    modport af (
        input  porta, portb, aluop,
        output outport, neg_f, over_f, zero_f
    );

    modport tb (
        output porta, portb, aluop,
        input  outport, neg_f, over_f, zero_f
    );

endinterface
`default_nettype wire

// File: rtl/alu_file.sv
`default_nettype none
//==============================================================================
// Module      : alu_file
// Description : Purely combinational ALU with negative, signed-overflow and
//               zero flags.
// Revision    : 1.0 - initial release
//==============================================================================
module alu_file
    import cpu_types_pkg::*;
(
    alu_file_if.af aif
);

    word_t w_sum;
    word_t w_diff;
    logic  w_slt;

    assign w_sum  = aif.porta + aif.portb;
    assign w_diff = aif.porta - aif.portb;
    assign w_slt  = $signed(aif.porta) < $signed(aif.portb);

    // Operation select and flag generation
    always_comb begin
        aif.outport = '0;
        aif.over_f  = 1'b0;
        case (aif.aluop)
            ALU_SLL:  aif.outport = aif.porta << aif.portb[4:0];
            ALU_SRL:  aif.outport = aif.porta >> aif.portb[4:0];
            ALU_SRA:  aif.outport = word_t'($signed(aif.porta) >>> aif.portb[4:0]);
            ALU_ADD: begin
                aif.outport = w_sum;
                aif.over_f  = (aif.porta[WORD_W-1] == aif.portb[WORD_W-1]) &&
                              (w_sum[WORD_W-1] != aif.porta[WORD_W-1]);
            end
            ALU_SUB: begin
                aif.outport = w_diff;
                aif.over_f  = (aif.porta[WORD_W-1] != aif.portb[WORD_W-1]) &&
                              (w_diff[WORD_W-1] != aif.porta[WORD_W-1]);
            end
            ALU_AND:  aif.outport = aif.porta & aif.portb;
            ALU_OR:   aif.outport = aif.porta | aif.portb;
            ALU_XOR:  aif.outport = aif.porta ^ aif.portb;
            ALU_NOR:  aif.outport = ~(aif.porta | aif.portb);
            ALU_SLT:  aif.outport = {{(WORD_W-1){1'b0}}, w_slt};
            ALU_SLTU: aif.outport = {{(WORD_W-1){1'b0}}, (aif.porta < aif.portb)};
            default:  aif.outport = '0;
        endcase
    end

    assign aif.neg_f  = aif.outport[WORD_W-1];
    assign aif.zero_f = (aif.outport == '0);

endmodule
`default_nettype wire

// File: rtl/alu_mult_seq.sv
`default_nettype none
//==============================================================================
// Module      : alu_mult_seq
// Description : Iterative unsigned shift-add multiplier. Every accumulation
//               add goes through the shared ALU; shifting, sequencing and
//               overflow tracking are local. Returns the low word of the
//               product plus overflow and zero flags over valid/ready.
// Revision    : 1.0 - initial release
//==============================================================================
module alu_mult_seq
    import cpu_types_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = MULT_CNT_W
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       req_valid,
    output logic       req_ready,
    input  word_t      opa,
    input  word_t      opb,
    output logic       resp_valid,
    input  logic       resp_ready,
    output word_t      result,
    output logic       ovf,
    output logic       zero,
    output word_t      alu_porta,
    output word_t      alu_portb,
    output aluop_t     alu_aluop,
    input  word_t      alu_outport
);

    mult_state_t      r_state;
    mult_state_t      w_state_nxt;

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_ovf;
    logic             r_zero;
    logic             r_resp_valid;

    logic             w_accept;
    logic             w_finish;
    logic             w_step;
    logic             w_release;
    logic             w_add_carry;
    logic             w_shift_loss;

    // The ALU sum wrapping below the old accumulator means a carry out of bit
    // WIDTH-1. A set top bit of mcand that is about to be shifted out is only
    // a real overflow if some higher multiplier bit will still add it in.
    assign w_add_carry  = (alu_outport < r_acc);
    assign w_shift_loss = r_mcand[WIDTH-1] && (r_mplier[WIDTH-1:1] != '0);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= MS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-state datapath strobes
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        w_step      = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            MS_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = MS_MUL;
                end
            end
            MS_MUL: begin
                if (r_mplier == '0) begin
                    w_finish    = 1'b1;
                    w_state_nxt = MS_DONE;
                end else begin
                    w_step = 1'b1;
                end
            end
            MS_DONE: begin
                if (resp_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = MS_IDLE;
                end
            end
            default: w_state_nxt = MS_IDLE;
        endcase
    end

    // Operand capture, shift-add iteration and result/flag registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_acc        <= '0;
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_cnt        <= '0;
            r_result     <= '0;
            r_ovf        <= 1'b0;
            r_zero       <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_acc    <= '0;
                r_mcand  <= opa;
                r_mplier <= opb;
                r_cnt    <= '0;
                r_ovf    <= 1'b0;
            end
            if (w_finish) begin
                r_result     <= r_acc;
                r_zero       <= (r_acc == '0);
                r_resp_valid <= 1'b1;
            end
            if (w_step) begin
                if (r_mplier[0]) begin
                    r_acc <= alu_outport;
                    if (w_add_carry) begin
                        r_ovf <= 1'b1;
                    end
                end
                if (w_shift_loss) begin
                    r_ovf <= 1'b1;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CNT_W'(1);
            end
            if (w_release) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

    assign req_ready  = (r_state == MS_IDLE);
    assign resp_valid = r_resp_valid;
    assign result     = r_result;
    assign ovf        = r_ovf;
    assign zero       = r_zero;

    // ALU is driven continuously; its output is only captured on add steps
    assign alu_porta  = r_acc;
    assign alu_portb  = r_mcand;
    assign alu_aluop  = ALU_ADD;

endmodule
`default_nettype wire

// File: tb/tb_alu_mult_seq.sv
`default_nettype none
//==============================================================================
// Module      : tb_alu_mult_seq
// Description : Self-checking bench for alu_mult_seq with the shared ALU
//               attached through alu_file_if.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_alu_mult_seq;
    import cpu_types_pkg::*;

    logic   CLK;
    logic   RST;
    logic   req_valid;
    logic   req_ready;
    word_t  opa;
    word_t  opb;
    logic   resp_valid;
    logic   resp_ready;
    word_t  result;
    logic   ovf;
    logic   zero;
    word_t  alu_porta;
    word_t  alu_portb;
    aluop_t alu_aluop;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_file_if aif ();

    alu_file u_alu (
        .aif (aif)
    );

    assign aif.porta = alu_porta;
    assign aif.portb = alu_portb;
    assign aif.aluop = alu_aluop;

    alu_mult_seq u_dut (
        .CLK         (CLK),
        .RST         (RST),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .opa         (opa),
        .opb         (opb),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .result      (result),
        .ovf         (ovf),
        .zero        (zero),
        .alu_porta   (alu_porta),
        .alu_portb   (alu_portb),
        .alu_aluop   (alu_aluop),
        .alu_outport (aif.outport)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        zero;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: full 64-bit product, latency from multiplier msb position
    function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] wa;
        logic [63:0] wb;
        wa = {32'd0, a};
        wb = {32'd0, b};
        return wa * wb;
    endfunction

    function automatic int ref_latency(input logic [31:0] b);
        int msb;
        msb = -1;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) msb = i;
        end
        return (msb < 0) ? 1 : msb + 2;
    endfunction

    task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input logic exp_ovf,
                           input logic exp_zero, input int exp_lat, input int hold);
        int lat;
        bit got;
        @(negedge CLK);
        check("req_ready_before", req_ready, 1'b1);
        opa        = a;
        opb        = b;
        req_valid  = 1'b1;
        resp_ready = 1'b0;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        opa       = $urandom;
        opb       = $urandom;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge CLK);
            lat++;
            #1;
            if (resp_valid) got = 1'b1;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("result", result, exp_res);
        check("ovf", ovf, exp_ovf);
        check("zero", zero, exp_zero);
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK);
            #1;
            check("hold_resp_valid", resp_valid, 1'b1);
            check("hold_req_ready", req_ready, 1'b0);
            check("hold_result", result, exp_res);
        end
        @(negedge CLK);
        resp_ready = 1'b1;
        @(posedge CLK);
        #1;
        check("release_resp_valid", resp_valid, 1'b0);
        check("release_req_ready", req_ready, 1'b1);
        resp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] p;
        bit          seen;

        vecs[0] = '{32'd7,        32'd6,        32'd42,       1'b0, 1'b0, 4,  0};
        vecs[1] = '{32'hDEADBEEF, 32'd0,        32'd0,        1'b0, 1'b1, 1,  0};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 33, 0};
        vecs[3] = '{32'h00010000, 32'h00010000, 32'd0,        1'b1, 1'b1, 18, 0};
        vecs[4] = '{32'd3,        32'd5,        32'd15,       1'b0, 1'b0, 4,  10};
        vecs[5] = '{32'd1,        32'h80000000, 32'h80000000, 1'b0, 1'b0, 33, 1};
        vecs[6] = '{32'h80000000, 32'd2,        32'd0,        1'b1, 1'b1, 3,  0};
        vecs[7] = '{32'd0,        32'h12345678, 32'd0,        1'b0, 1'b1, 30, 2};

        RST        = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        opa        = '0;
        opb        = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_result", result, 32'd0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_zero", zero, 1'b0);
        check("rst_aluop", alu_aluop, ALU_ADD);
        RST = 1'b0;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf,
                    vecs[i].zero, vecs[i].lat, vecs[i].hold);
        end

        // Reset in the middle of a long multiply: no response afterwards
        @(negedge CLK);
        opa       = 32'd5;
        opb       = 32'hFFFF0000;
        req_valid = 1'b1;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("midrst_req_ready", req_ready, 1'b1);
        check("midrst_resp_valid", resp_valid, 1'b0);
        check("midrst_result", result, 32'd0);
        @(negedge CLK);
        RST  = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge CLK);
            #1;
            if (resp_valid) seen = 1'b1;
        end
        check("midrst_no_response", seen, 1'b0);

        // Randomised operands against the arithmetic model
        for (int t = 0; t < 40; t++) begin
            ra = $urandom >> $urandom_range(0, 31);
            rb = $urandom >> $urandom_range(0, 31);
            if (t % 7 == 0) ra = 32'hFFFFFFFF;
            p = ref_product(ra, rb);
            run_txn(ra, rb, p[31:0], (p[63:32] != 32'd0), (p[31:0] == 32'd0),
                    ref_latency(rb), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
